// File: rtl/mult_seq_8bits.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_8bits
// Purpose  : Sequential 8x8 shift-add multiplier, signed or unsigned.
//            Produces a 16-bit product over 8 iterations.
//            START/BUSY/DONE handshake for stalling the CPU pipeline.
// Ports    : CLK        - clock, rising edge
//            RESET      - asynchronous active-low reset
//            START      - multiply request, sampled only when idle
//            OPA, OPB   - multiplicand / multiplier, captured on accept
//            SIGNED_OP  - 1 = two's-complement operands, 0 = unsigned
//            BUSY       - high while iterating
//            DONE       - one-cycle pulse, product valid from this cycle
//            RESULT     - product [7:0] (drives ALU mux in3)
//            RESULT_HI  - product [15:8]
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  input  logic             SIGNED_OP,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    result_q, result_d;

  logic [WIDTH-1:0] opa_mag;
  logic [WIDTH-1:0] opb_mag;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;

  // Magnitudes of the operands. Negating 0x80 yields 0x80, which is the
  // correct unsigned magnitude 128 for -128.
  always_comb begin
    opa_mag = OPA;
    opb_mag = OPB;
    if (SIGNED_OP && OPA[WIDTH-1]) opa_mag = ~OPA + 1'b1;
    if (SIGNED_OP && OPB[WIDTH-1]) opb_mag = ~OPB + 1'b1;
  end

  // Partial product for the current iteration: multiplicand weighted by the
  // iteration index, added only when the current multiplier bit is set.
  always_comb begin
    partial = '0;
    if (mplier_q[0]) partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    acc_sum = acc_q + partial;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          mcand_d  = opa_mag;
          mplier_d = opb_mag;
          neg_d    = SIGNED_OP & (OPA[WIDTH-1] ^ OPB[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_BUSY;
        end
      end

      S_BUSY: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q[WIDTH-1:0];
  assign RESULT_HI = result_q[PW-1:WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_8bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_8bits
// Purpose  : Self-checking bench for mult_seq_8bits. Stimulus pushes the
//            hand-computed product into a queue; a monitor pops and compares
//            on every DONE pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_8bits;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] OPA = '0;
  logic [7:0] OPB = '0;
  logic       SIGNED_OP = 1'b0;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;
  logic [7:0] RESULT_HI;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  mult_seq_8bits #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .OPA       (OPA),
    .OPB       (OPB),
    .SIGNED_OP (SIGNED_OP),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .RESULT_HI (RESULT_HI)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: compare every DONE against the oldest queued expectation.
  always @(negedge CLK) begin
    if (RESET) begin
      check("busy_done_exclusive", {15'd0, BUSY & DONE}, 16'd0);
      if (DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 16'd1, 16'd0);
        end else begin
          check("product", {RESULT_HI, RESULT}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp);
    @(negedge CLK);
    START = 1'b1; OPA = a; OPB = b; SIGNED_OP = s;
    exp_q.push_back(exp);
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Waits (bounded) for the DONE cycle; caller ends on the DONE negedge.
  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!DONE && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (!DONE) check({name, "_timeout"}, 16'd0, 16'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_busy", {15'd0, BUSY}, 16'd0);
    check("reset_done", {15'd0, DONE}, 16'd0);
    check("reset_result", {RESULT_HI, RESULT}, 16'h0000);
    @(negedge CLK);
    RESET = 1'b1;

    // 7*6 with exact BUSY/DONE timing
    issue(8'd7, 8'd6, 1'b0, 16'h002A);
    check("busy_cycle1", {15'd0, BUSY}, 16'd1);
    check("result_hold_at_start", {RESULT_HI, RESULT}, 16'h0000);
    for (int i = 2; i <= 8; i++) begin
      @(negedge CLK);
      check($sformatf("busy_cycle%0d", i), {15'd0, BUSY}, 16'd1);
    end
    @(negedge CLK);
    check("done_after_8", {15'd0, DONE}, 16'd1);
    check("busy_low_at_done", {15'd0, BUSY}, 16'd0);
    @(negedge CLK);
    check("done_cleared", {15'd0, DONE}, 16'd0);
    check("result_held", {RESULT_HI, RESULT}, 16'h002A);

    // Boundary operand patterns
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01); wait_done("ff_ff_u");
    issue(8'hFF, 8'hFF, 1'b1, 16'h0001); wait_done("m1_m1_s");
    issue(8'hFD, 8'h05, 1'b1, 16'hFFF1); wait_done("m3_5_s");
    issue(8'h80, 8'h80, 1'b1, 16'h4000); wait_done("m128_m128_s");
    issue(8'h00, 8'h00, 1'b0, 16'h0000); wait_done("zero");
    issue(8'h7F, 8'h80, 1'b1, 16'hC080); wait_done("127_m128_s");

    // START while busy is ignored
    issue(8'd2, 8'd3, 1'b0, 16'h0006);
    @(negedge CLK);
    START = 1'b1; OPA = 8'd5; OPB = 8'd5;
    @(negedge CLK);
    START = 1'b0;
    wait_done("ignore");
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE) check("second_done", 16'd1, 16'd0);
    end
    check("ignore_result", {RESULT_HI, RESULT}, 16'h0006);

    // Asynchronous reset mid-multiply
    issue(8'd9, 8'd9, 1'b0, 16'h0051);
    repeat (3) @(negedge CLK);
    #2;
    RESET = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("async_rst_busy", {15'd0, BUSY}, 16'd0);
    check("async_rst_done", {15'd0, DONE}, 16'd0);
    check("async_rst_result", {RESULT_HI, RESULT}, 16'h0000);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    issue(8'd4, 8'd4, 1'b0, 16'h0010); wait_done("after_reset");

    // Back-to-back: START held through DONE
    @(negedge CLK);
    START = 1'b1; OPA = 8'd2; OPB = 8'd2; SIGNED_OP = 1'b0;
    exp_q.push_back(16'h0004);
    @(negedge CLK);
    OPA = 8'd3; OPB = 8'd3;
    exp_q.push_back(16'h0009);
    wait_done("b2b_first");
    @(negedge CLK);
    START = 1'b0;
    check("b2b_busy_again", {15'd0, BUSY}, 16'd1);
    check("b2b_hold", {RESULT_HI, RESULT}, 16'h0004);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (RESULT != 8'h04) check("b2b_hold_busy", {RESULT_HI, RESULT}, 16'h0004);
    end
    @(negedge CLK);
    check("b2b_busy_cycle8", {15'd0, BUSY}, 16'd1);
    @(negedge CLK);
    check("b2b_second_done", {15'd0, DONE}, 16'd1);
    @(negedge CLK);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
